rv32_program_loader: RTL and testbench

//  Upstream feeder for the single-cycle RV32 core. Takes a byte stream (UART RX side), buffers a

---
 rtl/rv32_loader_pkg.sv | 19 +
 rtl/rv32_program_loader_if.sv | 9 +
 rtl/loader_word_buf.sv | 24 ++
 rtl/rv32_program_loader.sv | 195 +++++++++++++++++++
 tb/tb_rv32_program_loader.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32_loader_pkg.sv
// Shared types and constants for the RV32 program loader.
package rv32_loader_pkg;

   typedef enum logic [3:0] {
      IDLE,
      HDR0,
      HDR1,
      PAYLOAD,
      CHECK,
      STREAM,
      RST1,
      DONE,
      ERROR
   } state_t;

   localparam int unsigned HDR_W          = 16;
   localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/rv32_program_loader_if.sv
// Byte stream handshake: master sources bytes, slave (the loader) accepts them.
interface rv32_program_loader_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;

   modport master (output rx_data, output rx_valid, input rx_ready);
   modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/loader_word_buf.sv
// Program buffer: synchronous RAM, one write port, one registered read port.
// A read of the address being written returns the new data.
module loader_word_buf #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   // Write port and registered read with write-through bypass.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (we && (waddr == raddr)) rdata <= wdata;
      else                        rdata <= mem[raddr];
   end

endmodule

// File: rtl/rv32_program_loader.sv
// Buffers a length-prefixed program from a byte stream, then streams it into the
// core's instruction memory while holding the core in sequential-PC mode, and
// finally re-resets the core and lets it run from address 0.
// Optional feature macro: LOADER_CHECKSUM_EN (trailing frame checksum byte).
module rv32_program_loader
   import rv32_loader_pkg::*;
#(
   parameter int unsigned MAX_WORDS = 256,
   parameter int unsigned CNT_W     = 9
) (
   input  logic                  clk,
   input  logic                  Reset,
   rv32_program_loader_if.slave  rx,
   output logic                  core_reset,
   output logic                  Write,
   output logic                  WE_mem,
   output logic [31:0]           WD_mem,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   localparam int unsigned AW = $clog2(MAX_WORDS);

   state_t           state_q, state_d;
   logic [7:0]       cnt_lo_q, cnt_lo_d;
   logic [HDR_W-1:0] n_q, n_d;
   logic [1:0]       byte_cnt_q, byte_cnt_d;
   logic [23:0]      word_asm_q, word_asm_d;
   logic [CNT_W-1:0] idx_q, idx_d;
   logic             rdy, xfer;
   logic             buf_we;
   logic [AW-1:0]    buf_waddr, buf_raddr;
   logic [31:0]      buf_wdata, buf_rdata;

   assign rx.rx_ready = rdy;
   assign xfer        = rx.rx_valid & rdy;

`ifdef LOADER_CHECKSUM_EN
   logic [7:0] sum_q, sum_d;

   // Running byte sum of the frame, restarted by the count-low byte.
   always_comb begin
      sum_d = sum_q;
      if (xfer) begin
         if ((state_q == IDLE) || (state_q == DONE)) sum_d = rx.rx_data;
         else                                        sum_d = sum_q + rx.rx_data;
      end
   end

   // Checksum accumulator.
   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) sum_q <= '0;
      else        sum_q <= sum_d;
   end
`endif

   loader_word_buf #(
      .DEPTH (MAX_WORDS),
      .AW    (AW)
   ) u_buf (
      .clk   (clk),
      .we    (buf_we),
      .waddr (buf_waddr),
      .wdata (buf_wdata),
      .raddr (buf_raddr),
      .rdata (buf_rdata)
   );

   // Next-state, word assembly and buffer port control.
   always_comb begin
      state_d    = state_q;
      cnt_lo_d   = cnt_lo_q;
      n_d        = n_q;
      byte_cnt_d = byte_cnt_q;
      word_asm_d = word_asm_q;
      idx_d      = idx_q;
      buf_we     = 1'b0;
      buf_waddr  = idx_q[AW-1:0];
      buf_wdata  = {rx.rx_data, word_asm_q};
      // Address 0 is read by default so word 0 is ready on the first STREAM cycle.
      buf_raddr  = '0;
      unique case (state_q)
         IDLE, DONE: begin
            if (xfer) begin
               cnt_lo_d = rx.rx_data;
               state_d  = HDR0;
            end
         end
         HDR0: state_d = HDR1;
         HDR1: begin
            if (xfer) begin
               n_d        = {rx.rx_data, cnt_lo_q};
               idx_d      = '0;
               byte_cnt_d = '0;
               if (n_d == '0)                  state_d = RST1;
               else if (32'(n_d) > MAX_WORDS) state_d = ERROR;
               else                            state_d = PAYLOAD;
            end
         end
         PAYLOAD: begin
            if (xfer) begin
               byte_cnt_d = byte_cnt_q + 2'd1;
               word_asm_d = {rx.rx_data, word_asm_q[23:8]};
               if (byte_cnt_q == 2'(BYTES_PER_WORD - 1)) begin
                  buf_we = 1'b1;
                  idx_d  = idx_q + CNT_W'(1);
                  if (HDR_W'(idx_q) == (n_q - 16'd1)) begin
                     idx_d = '0;
`ifdef LOADER_CHECKSUM_EN
                     state_d = CHECK;
`else
                     state_d = STREAM;
`endif
                  end
               end
            end
         end
         CHECK: begin
`ifdef LOADER_CHECKSUM_EN
            if (xfer) begin
               if (8'(sum_q + rx.rx_data) == 8'd0) state_d = STREAM;
               else                                state_d = ERROR;
            end
`else
            state_d = IDLE;
`endif
         end
         STREAM: begin
            // Prefetch word k+1 while word k is presented.
            buf_raddr = AW'(idx_q + CNT_W'(1));
            idx_d     = idx_q + CNT_W'(1);
            if (HDR_W'(idx_q) == (n_q - 16'd1)) state_d = RST1;
         end
         RST1:    state_d = DONE;
         ERROR:   state_d = ERROR;
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         state_q    <= IDLE;
         cnt_lo_q   <= '0;
         n_q        <= '0;
         byte_cnt_q <= '0;
         word_asm_q <= '0;
         idx_q      <= '0;
      end else begin
         state_q    <= state_d;
         cnt_lo_q   <= cnt_lo_d;
         n_q        <= n_d;
         byte_cnt_q <= byte_cnt_d;
         word_asm_q <= word_asm_d;
         idx_q      <= idx_d;
      end
   end

   // Moore outputs decoded from state; no byte is accepted while Reset is low.
   always_comb begin
      rdy        = 1'b0;
      core_reset = 1'b1;
      Write      = 1'b1;
      WE_mem     = 1'b0;
      WD_mem     = '0;
      busy       = 1'b0;
      done       = 1'b0;
      error      = 1'b0;
      unique case (state_q)
         IDLE:                 rdy = 1'b1;
         HDR0, RST1:           busy = 1'b1;
         HDR1, PAYLOAD, CHECK: begin
            rdy  = 1'b1;
            busy = 1'b1;
         end
         STREAM: begin
            busy       = 1'b1;
            core_reset = 1'b0;
            WE_mem     = 1'b1;
            WD_mem     = buf_rdata;
         end
         DONE: begin
            rdy        = 1'b1;
            core_reset = 1'b0;
            Write      = 1'b0;
            done       = 1'b1;
         end
         ERROR:   error = 1'b1;
         default: ;
      endcase
      if (!Reset) rdy = 1'b0;
   end

endmodule

// File: tb/tb_rv32_program_loader.sv
// Scoreboard bench for rv32_program_loader: frames are built from word lists,
// expected instruction-memory writes are queued, and a monitor checks every write.
`timescale 1ns/1ps
module tb_rv32_program_loader;

   localparam int unsigned MAX_WORDS = 256;

   logic        clk   = 1'b0;
   logic        Reset = 1'b0;
   logic        core_reset, Write, WE_mem, busy, done, error;
   logic [31:0] WD_mem;

   rv32_program_loader_if rx_if ();

   rv32_program_loader #(
      .MAX_WORDS (MAX_WORDS),
      .CNT_W     (9)
   ) dut (
      .clk        (clk),
      .Reset      (Reset),
      .rx         (rx_if.slave),
      .core_reset (core_reset),
      .Write      (Write),
      .WE_mem     (WE_mem),
      .WD_mem     (WD_mem),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          we_runs = 0;
   int          last_we_cyc = 0;
   logic        prev_we = 1'b0;
   logic [31:0] exp_q[$];
   logic [31:0] prog[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every instruction-memory write must match the next queued word.
   always @(negedge clk) begin
      if (Reset && WE_mem) begin
         if (!prev_we) we_runs++;
         last_we_cyc = cyc;
         if (exp_q.size() == 0) chk("unexpected_we", {31'd0, WE_mem}, 32'd0);
         else                   chk("wd_mem", WD_mem, exp_q.pop_front());
         chk("stream_ctl", {30'd0, core_reset, Write}, 32'd1);
      end
      prev_we = Reset && WE_mem;
   end

   // Called at a negedge; returns at the negedge following the transfer.
   task automatic send_byte(input logic [7:0] b);
      int t = 0;
      rx_if.rx_data  = b;
      rx_if.rx_valid = 1'b1;
      while (!rx_if.rx_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) chk("rx_timeout", {31'd0, rx_if.rx_ready}, 32'd1);
      else          @(negedge clk);
      rx_if.rx_valid = 1'b0;
   endtask

   // Reference: frame = count LE, payload words LE, optional checksum byte.
   task automatic send_frame(input logic [15:0] n, input int gap_max, input bit bad_cs);
      logic [7:0] bytes[$];
      logic [7:0] s;
      logic [31:0] w;
      bit ok;
      ok = (n >= 16'd1) && (32'(n) <= MAX_WORDS);
      bytes.push_back(n[7:0]);
      bytes.push_back(n[15:8]);
      if (ok) begin
         for (int i = 0; i < int'(n); i++) begin
            w = prog[i];
            for (int j = 0; j < 4; j++) bytes.push_back(w[8*j +: 8]);
         end
`ifdef LOADER_CHECKSUM_EN
         s = 8'd0;
         foreach (bytes[i]) s = s + bytes[i];
         s = 8'd0 - s;
         if (bad_cs) s = s + 8'd1;
         bytes.push_back(s);
`endif
         if (!bad_cs) for (int i = 0; i < int'(n); i++) exp_q.push_back(prog[i]);
      end
      foreach (bytes[i]) begin
         if (i >= 2 && gap_max > 0) repeat ($urandom_range(gap_max, 0)) @(negedge clk);
         send_byte(bytes[i]);
      end
   endtask

   task automatic rand_prog(input int n);
      prog.delete();
      for (int i = 0; i < n; i++) prog.push_back($urandom);
   endtask

   task automatic expect_done(input int n, input int runs0);
      int t = 0;
      while (!done && t < 5000) begin
         @(negedge clk);
         t++;
      end
      chk("done_reached", {31'd0, done}, 32'd1);
      chk("done_ctl", {27'd0, core_reset, Write, busy, error, rx_if.rx_ready}, 32'd1);
      chk("queue_drained", exp_q.size(), 32'd0);
      chk("we_runs", we_runs - runs0, (n > 0) ? 32'd1 : 32'd0);
      if (n > 0) chk("rst1_gap", cyc - last_we_cyc, 32'd2);
   endtask

   task automatic expect_error(input int runs0);
      for (int r = 0; r < 2; r++) begin
         chk("err_flag", {31'd0, error}, 32'd1);
         chk("err_ctl", {28'd0, rx_if.rx_ready, Write, core_reset, busy}, 32'd6);
         repeat (5) @(negedge clk);
      end
      chk("err_no_we", we_runs - runs0, 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      Reset          = 1'b0;
      rx_if.rx_valid = 1'b0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      chk("rst_outs", {25'd0, core_reset, Write, WE_mem, rx_if.rx_ready, busy, done, error},
          32'h60);
      chk("rst_wd", WD_mem, 32'd0);
      Reset = 1'b1;
      @(negedge clk);
      chk("idle_ready", {30'd0, rx_if.rx_ready, busy}, 32'd2);
   endtask

   initial begin
      int runs0;
      int n;
      int t;
      rx_if.rx_data  = 8'd0;
      rx_if.rx_valid = 1'b0;
      do_reset();

      // Fixed two-instruction program.
      prog.delete();
      prog.push_back(32'h0050_0093);
      prog.push_back(32'h0010_0113);
      runs0 = we_runs;
      send_frame(16'd2, 0, 1'b0);
      expect_done(2, runs0);

      // Empty program, restarted straight from DONE.
      runs0 = we_runs;
      send_frame(16'd0, 0, 1'b0);
      expect_done(0, runs0);

      // Random programs, each sent gap-free and then with random rx_valid gaps.
      for (int f = 0; f < 3; f++) begin
         n = $urandom_range(8, 1);
         rand_prog(n);
         for (int g = 0; g < 2; g++) begin
            runs0 = we_runs;
            send_frame(16'(n), g * 6, 1'b0);
            expect_done(n, runs0);
         end
      end

      // Single word and full-buffer boundaries.
      rand_prog(1);
      runs0 = we_runs;
      send_frame(16'd1, 2, 1'b0);
      expect_done(1, runs0);
      rand_prog(MAX_WORDS);
      runs0 = we_runs;
      send_frame(16'(MAX_WORDS), 0, 1'b0);
      expect_done(MAX_WORDS, runs0);

      // Oversized counts trap in ERROR until Reset.
      runs0 = we_runs;
      send_frame(16'd300, 0, 1'b0);
      expect_error(runs0);
      do_reset();
      runs0 = we_runs;
      send_frame(16'(MAX_WORDS + 1), 0, 1'b0);
      expect_error(runs0);
      do_reset();

      // Reset asserted on the second STREAM cycle of a four-word program.
      rand_prog(4);
      send_frame(16'd4, 0, 1'b0);
      t = 0;
      while (!WE_mem && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("stream_k0", {31'd0, WE_mem}, 32'd1);
      @(negedge clk);
      chk("stream_k1", {31'd0, WE_mem}, 32'd1);
      #1 Reset = 1'b0;
      @(negedge clk);
      chk("midrst_outs", {29'd0, WE_mem, core_reset, busy}, 32'd2);
      exp_q.delete();
      Reset = 1'b1;
      @(negedge clk);
      chk("midrst_idle", {30'd0, rx_if.rx_ready, busy}, 32'd2);

`ifdef LOADER_CHECKSUM_EN
      rand_prog(3);
      runs0 = we_runs;
      send_frame(16'd3, 2, 1'b0);
      expect_done(3, runs0);
      runs0 = we_runs;
      send_frame(16'd3, 0, 1'b1);
      expect_error(runs0);
      do_reset();
`endif

      // Recovery after reset.
      rand_prog(5);
      runs0 = we_runs;
      send_frame(16'd5, 3, 1'b0);
      expect_done(5, runs0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
